// File: rtl/transport_block_deshaper.sv
// Rx transport-block deshaper: ping-pong buffers whole blocks, strips trailing zero padding
// and streams the remaining payload bytes out under an oval/ireq handshake.
module transport_block_deshaper #(
  parameter int size_tblck = 480,
  parameter int min_pad    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ival,
  input  logic [7:0] idata,
  input  logic       isof,
  input  logic       ireq,
  output logic       oval,
  output logic [7:0] odata,
  output logic       olast,
  output logic       ooverflow,
  output logic       osync_err
);

  localparam int cw = $clog2(size_tblck);
  localparam int lw = $clog2(size_tblck + 1);
  localparam logic [cw-1:0] last_idx = cw'(size_tblck - 1);
  localparam logic [lw-1:0] blk_len  = lw'(size_tblck);
  localparam logic [lw-1:0] pad_min  = lw'(min_pad);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  // write side state
  logic [cw-1:0] wr_cnt_reg;
  logic [lw-1:0] zrun_reg;
  logic          wr_bank_reg;
  logic          drop_reg;
  logic [1:0]    full_reg;
  logic [lw-1:0] len_reg [2];

  // read side state
  state_t        state_reg;
  logic          rd_bank_reg;
  logic [cw-1:0] rd_cnt_reg;
  logic [lw-1:0] cur_len_reg;

  logic          start, zero_byte, blk_end, commit, done_xfer, drop_now, rd_en;
  logic [cw-1:0] idx, waddr, raddr;
  logic [lw-1:0] zrun_next, len_next;
  logic [1:0]    free_mask, full_eff, set_mask, we, re;
  logic [15:0]   rdata_bus;

  always_comb begin
    start     = ival & (isof | (wr_cnt_reg == '0));
    idx       = start ? '0 : wr_cnt_reg;
    zero_byte = (idata == 8'd0);
    done_xfer = (state_reg == SEND) & ireq & olast;
    // a bank freed this cycle is already usable by a block starting this cycle
    free_mask = done_xfer ? (2'b01 << rd_bank_reg) : 2'b00;
    full_eff  = full_reg & ~free_mask;
    drop_now  = start ? full_eff[wr_bank_reg] : drop_reg;
    if (start)
      zrun_next = zero_byte ? lw'(1) : '0;
    else if (!zero_byte)
      zrun_next = '0;
    else if (zrun_reg == blk_len)
      zrun_next = zrun_reg;
    else
      zrun_next = zrun_reg + lw'(1);
    blk_end   = ival & (idx == last_idx);
    len_next  = (zrun_next >= pad_min) ? (blk_len - zrun_next) : blk_len;
    commit    = blk_end & ~drop_now & (len_next != '0);
    set_mask  = commit ? (2'b01 << wr_bank_reg) : 2'b00;
    waddr     = idx;
    we        = 2'b00;
    if (ival && !drop_now) we[wr_bank_reg] = 1'b1;
    rd_en     = (state_reg == FETCH) | ((state_reg == SEND) & ireq & ~olast);
    raddr     = (state_reg == FETCH) ? '0 : (rd_cnt_reg + cw'(1));
    re        = 2'b00;
    if (rd_en) re[rd_bank_reg] = 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [7:0] mem [size_tblck];
      logic [7:0] q_reg;
      always_ff @(posedge clk) begin
        if (we[gi]) mem[waddr] <= idata;
        if (!rst) q_reg <= 8'd0;
        else if (re[gi]) q_reg <= mem[raddr];
      end
      assign rdata_bus[gi*8 +: 8] = q_reg;
    end
  endgenerate

  assign odata = rd_bank_reg ? rdata_bus[15:8] : rdata_bus[7:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_cnt_reg  <= '0;
      zrun_reg    <= '0;
      wr_bank_reg <= 1'b0;
      drop_reg    <= 1'b0;
      full_reg    <= 2'b00;
      len_reg[0]  <= '0;
      len_reg[1]  <= '0;
      state_reg   <= IDLE;
      rd_bank_reg <= 1'b0;
      rd_cnt_reg  <= '0;
      cur_len_reg <= '0;
      oval        <= 1'b0;
      olast       <= 1'b0;
      ooverflow   <= 1'b0;
      osync_err   <= 1'b0;
    end else begin
      ooverflow <= start & full_eff[wr_bank_reg];
      osync_err <= ival & isof & (wr_cnt_reg != '0);
      full_reg  <= full_eff | set_mask;
      if (ival) begin
        wr_cnt_reg <= blk_end ? '0 : (idx + cw'(1));
        zrun_reg   <= zrun_next;
        drop_reg   <= drop_now;
        if (commit) begin
          len_reg[wr_bank_reg] <= len_next;
          wr_bank_reg          <= ~wr_bank_reg;
        end
      end

      case (state_reg)
        IDLE: begin
          if (full_reg[rd_bank_reg]) begin
            cur_len_reg <= len_reg[rd_bank_reg];
            state_reg   <= FETCH;
          end
        end
        FETCH: begin
          state_reg  <= SEND;
          oval       <= 1'b1;
          olast      <= (cur_len_reg == lw'(1));
          rd_cnt_reg <= '0;
        end
        SEND: begin
          if (ireq) begin
            if (olast) begin
              oval        <= 1'b0;
              olast       <= 1'b0;
              rd_bank_reg <= ~rd_bank_reg;
              if (full_reg[~rd_bank_reg]) begin
                cur_len_reg <= len_reg[~rd_bank_reg];
                state_reg   <= FETCH;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              rd_cnt_reg <= rd_cnt_reg + cw'(1);
              // olast flags the byte whose index is len-1 as it is loaded
              olast      <= ((lw'(rd_cnt_reg) + lw'(2)) == cur_len_reg);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transport_block_deshaper.sv
// Scoreboard bench for transport_block_deshaper: directed blocks push expected payload,
// a negedge monitor pops and compares every transfer.
module tb_transport_block_deshaper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ival = 1'b0;
  logic [7:0] idata = 8'd0;
  logic       isof = 1'b0;
  logic       ireq = 1'b1;
  logic       oval, olast, ooverflow, osync_err;
  logic [7:0] odata;

  transport_block_deshaper #(.size_tblck(480), .min_pad(16)) dut (
    .clk(clk), .rst(rst), .ival(ival), .idata(idata), .isof(isof), .ireq(ireq),
    .oval(oval), .odata(odata), .olast(olast), .ooverflow(ooverflow), .osync_err(osync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] sb [$];
  int vecs = 0;
  int miss = 0;
  int ovf_cnt = 0;
  int sync_cnt = 0;
  int last_rise_cyc = 0;
  int last_wr_cyc = 0;
  bit oval_q = 1'b0;

  always @(negedge clk) begin
    logic [8:0] exp;
    if (rst) begin
      if (ooverflow) ovf_cnt++;
      if (osync_err) sync_cnt++;
      if (oval && !oval_q) last_rise_cyc = cyc;
      oval_q = oval;
      if (oval && ireq) begin
        vecs++;
        if (sb.size() == 0) begin
          miss++;
          $display("FAIL unexpected_out: got data %h last %b, required no output", odata, olast);
        end else begin
          exp = sb.pop_front();
          if ({olast, odata} !== exp)
            begin
              miss++;
              $display("FAIL out_byte: got data %h last %b, required data %h last %b",
                       odata, olast, exp[7:0], exp[8]);
            end
        end
      end
    end else begin
      oval_q = 1'b0;
    end
  end

  function automatic logic [7:0] pat(input int mode, input int i);
    case (mode)
      0: pat = 8'((i % 224) + 1);
      1: pat = (i < 100) ? 8'hA5 : 8'h00;
      2: pat = (i < 470) ? 8'h5A : 8'h00;
      3: pat = 8'h00;
      4: pat = 8'(((i * 7 + 3) % 255) + 1);
      default: pat = 8'((i % 200) + 8'h30);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    vecs++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic send_block(input int mode, input int nbytes, input int exp_len);
    for (int i = 0; i < nbytes; i++) begin
      ival  = 1'b1;
      idata = pat(mode, i);
      isof  = (i == 0);
      @(posedge clk); #1;
    end
    ival = 1'b0;
    isof = 1'b0;
    last_wr_cyc = cyc;
    for (int i = 0; i < exp_len; i++)
      sb.push_back({(i == exp_len - 1), pat(mode, i)});
    $display("block mode %0d: %0d bytes in, %0d payload bytes expected", mode, nbytes, exp_len);
  endtask

  task automatic drain(input string name, input bit stall);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 3000) begin
      ireq = stall ? ((k % 3) != 0) : 1'b1;
      @(posedge clk); #1;
      k++;
    end
    ireq = 1'b1;
    check({name, "_drain_left"}, sb.size(), 0);
    sb.delete();
    repeat (8) @(posedge clk);
    #1;
    check({name, "_idle_oval"}, int'(oval), 0);
  endtask

  initial begin
    int ovf0, sync0, k;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_oval", int'(oval), 0);
    check("rst_olast", int'(olast), 0);
    check("rst_odata", int'(odata), 0);
    check("rst_ovf", int'(ooverflow), 0);
    check("rst_sync", int'(osync_err), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1) nonzero block, full length, latency 2
    send_block(0, 480, 480);
    drain("t1", 1'b0);
    check("t1_latency", last_rise_cyc - last_wr_cyc, 2);

    // 2) long zero padding stripped
    send_block(1, 480, 100);
    drain("t2", 1'b0);

    // 3) short zero tail kept, output stalled periodically
    send_block(2, 480, 480);
    drain("t3", 1'b1);

    // 4) three blocks with no downstream demand
    ovf0 = ovf_cnt;
    ireq = 1'b0;
    send_block(0, 480, 480);
    send_block(4, 480, 480);
    send_block(5, 480, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t4_ovf_pulses", ovf_cnt - ovf0, 1);
    check("t4_oval_waiting", int'(oval), 1);
    drain("t4", 1'b0);
    check("t4_ovf_after", ovf_cnt - ovf0, 1);

    // 5) isof mid-block resynchronises
    sync0 = sync_cnt;
    send_block(0, 200, 0);
    send_block(5, 480, 480);
    drain("t5", 1'b0);
    check("t5_sync_pulses", sync_cnt - sync0, 1);

    // 6) all-zero block, then reset mid-transfer
    send_block(3, 480, 0);
    send_block(4, 480, 480);
    k = 0;
    while (sb.size() > 430 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    check("t6_partial_out", int'(sb.size() <= 430), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_oval", int'(oval), 0);
    check("t6_rst_olast", int'(olast), 0);
    rst = 1'b1;
    sb.delete();
    repeat (4) @(posedge clk);
    #1;
    check("t6_post_rst_oval", int'(oval), 0);
    send_block(5, 480, 480);
    drain("t6", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
